// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-port arbiter.
// The optional watchdog is enabled with the UART_TX_ARB_TIMEOUT_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_WRITE     = 3'd2,
        ST_WAIT_TAKE = 3'd3,
        ST_WAIT_RDY  = 3'd4
    } arb_state_t;

    // Transmitter data-register address.
    localparam logic [7:0] UDR_ADDR = 8'hC6;

    // Watchdog terminal count for the wait states.
    localparam logic [15:0] UART_TX_ARB_WDOG_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot grant for the first valid
// index at or after the pointer, wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic            o_found
);

    logic [PW-1:0] w_idx;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Scan from the pointer and keep the first valid requester.
    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = wrap_idx(i_ptr, k);
            if (!o_found && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with burst lock sharing the UART transmitter's
// data-register write port between NREQ byte-stream requesters.
// Optional watchdog on the wait states: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NREQ      = 4,
    parameter logic [7:0] TX_ADDR   = UDR_ADDR,
    parameter int         BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              udre_i,
    input  logic              txc_i,
    output logic              wr_o,
    output logic [7:0]        addr_o,
    output logic [7:0]        dout_o,
    output logic              tcack_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int         PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    arb_state_t      r_state;
    logic [NREQ-1:0] r_grant;
    logic [PW-1:0]   r_win;
    logic [PW-1:0]   r_ptr;
    logic [7:0]      r_burst;
    logic            r_last;
    logic            r_pending;
    logic            r_wr;
    logic [7:0]      r_addr;
    logic [7:0]      r_dout;
    logic            r_tcack;
    logic [NREQ-1:0] r_ready;
    logic            r_busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0]     r_wdog;
    logic            r_err;
`endif

    logic [NREQ-1:0] w_pick;
    logic            w_found;
    logic [PW-1:0]   w_pick_idx;
    logic [PW-1:0]   w_pick_ptr;
    logic [PW-1:0]   w_ptr_next;
    logic [7:0]      w_win_byte;
    logic            w_win_valid;
    logic            w_win_last;
    logic            w_lock;

    assign w_ptr_next = (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
    // On release the fresh round starts just past the previous owner.
    assign w_pick_ptr = (r_state == ST_WAIT_RDY) ? w_ptr_next : r_ptr;
    assign w_lock     = !r_last && (r_burst < BURST_LIM);

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .i_valid (req_valid),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_pick),
        .o_found (w_found)
    );

    // Mux the owner's byte/flags and encode the picked index.
    always_comb begin
        w_win_byte  = '0;
        w_win_valid = 1'b0;
        w_win_last  = 1'b0;
        w_pick_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_win_byte  = w_win_byte | req_data[8*i +: 8];
                w_win_valid = w_win_valid | req_valid[i];
                w_win_last  = w_win_last | req_last[i];
            end
            if (w_pick[i]) w_pick_idx = PW'(i);
        end
    end

    // Arbitration FSM with registered transmitter-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_win     <= '0;
            r_ptr     <= '0;
            r_burst   <= '0;
            r_last    <= 1'b0;
            r_pending <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_dout    <= '0;
            r_tcack   <= 1'b0;
            r_ready   <= '0;
            r_busy    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_wdog    <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_wr    <= 1'b0;
            r_ready <= '0;
            r_tcack <= 1'b0;
            // Acknowledge transmit-complete only once nothing is in flight.
            if (r_state == ST_IDLE && r_pending && udre_i && txc_i) begin
                r_tcack   <= 1'b1;
                r_pending <= 1'b0;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (r_state == ST_WAIT_TAKE || r_state == ST_WAIT_RDY) r_wdog <= r_wdog + 16'd1;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_found && udre_i) begin
                        r_grant <= w_pick;
                        r_win   <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Holding here while udre_i is low keeps wr_o off a busy register.
                    if (udre_i) begin
                        r_dout  <= w_win_byte;
                        r_last  <= w_win_last;
                        r_addr  <= TX_ADDR;
                        r_wr    <= 1'b1;
                        r_ready <= r_grant;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_burst < BURST_LIM) r_burst <= r_burst + 8'd1;
                    r_pending <= 1'b1;
                    r_state   <= ST_WAIT_TAKE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    r_wdog    <= '0;
`endif
                end
                ST_WAIT_TAKE: begin
                    if (!udre_i) begin
                        r_state <= ST_WAIT_RDY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        r_wdog  <= '0;
`endif
                    end
                end
                ST_WAIT_RDY: begin
                    if (udre_i) begin
                        if (w_lock) begin
                            // Locked owner keeps the port; wait here if it has no byte yet.
                            if (w_win_valid) r_state <= ST_GRANT;
                        end else begin
                            r_ptr   <= w_ptr_next;
                            r_burst <= '0;
                            if (w_found) begin
                                r_grant <= w_pick;
                                r_win   <= w_pick_idx;
                                r_state <= ST_GRANT;
                            end else begin
                                r_grant <= '0;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
            if ((r_state == ST_WAIT_TAKE || r_state == ST_WAIT_RDY) &&
                (r_wdog == UART_TX_ARB_WDOG_MAX)) begin
                r_err   <= 1'b1;
                r_grant <= '0;
                r_ptr   <= w_ptr_next;
                r_burst <= '0;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
            end
`endif
        end
    end

    assign wr_o      = r_wr;
    assign addr_o    = r_addr;
    assign dout_o    = r_dout;
    assign tcack_o   = r_tcack;
    assign req_ready = r_ready;
    assign grant_o   = r_grant;
    assign busy_o    = r_busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign err_o     = r_err;
`else
    assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transaction-level
// arbitration model and a simple transmitter model.
module tb_uart_tx_arbiter;

    localparam int         NREQ      = 4;
    localparam int         BURST_MAX = 16;
    localparam logic [7:0] TX_ADDR   = 8'hC6;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              udre_i;
    logic              txc_i;
    logic              wr_o;
    logic [7:0]        addr_o;
    logic [7:0]        dout_o;
    logic              tcack_o;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;
    logic              err_o;

    uart_tx_arbiter #(.NREQ(NREQ), .TX_ADDR(TX_ADDR), .BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .udre_i    (udre_i),
        .txc_i     (txc_i),
        .wr_o      (wr_o),
        .addr_o    (addr_o),
        .dout_o    (dout_o),
        .tcack_o   (tcack_o),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    int n_chk;
    int n_pass;

    // Per-requester byte queues: bit 8 is the last flag.
    logic [8:0] q [NREQ][$];

    // Arbitration model state.
    int m_ptr;
    bit m_lock;
    int m_owner;
    int m_cnt;
    bit m_pend;

    // Transmitter model: 0 ready, 1 waiting to take, 2 register full.
    int x_phase;
    int x_d1;
    int x_d2;
    bit x_stuck;
    bit x_long;
    bit txc_rand;
    bit txc_force;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int pick_first();
        for (int k = 0; k < NREQ; k++) begin
            if (q[(m_ptr + k) % NREQ].size() > 0) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_burst(input int r, input int n, input bit rand_last);
        for (int k = 0; k < n; k++) begin
            logic [8:0] e;
            e[7:0] = 8'($urandom);
            e[8]   = (k == n - 1) ? 1'b1 : (rand_last ? ($urandom_range(0, 3) == 0) : 1'b0);
            q[r].push_back(e);
        end
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 1'b0;
        for (int c = 0; c < bound && !done; c++) begin
            @(posedge clk);
            #2;
            if (all_empty() && !busy_o && x_phase == 0) done = 1'b1;
        end
        chk_eq("drain", 32'(done), 32'(1));
    endtask

    task automatic model_reset();
        m_ptr = 0; m_lock = 0; m_owner = 0; m_cnt = 0; m_pend = 0;
        x_phase = 0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester, transmitter and write-checking process, active on negedge.
    initial begin
        int         e;
        logic [8:0] b;
        req_valid = '0; req_data = '0; req_last = '0;
        udre_i = 1'b1; txc_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tcack_o) begin
                    chk_eq("tcack_pending", 32'(m_pend), 32'(1));
                    chk_eq("tcack_outstanding", 32'(x_phase), 32'(0));
                    m_pend = 1'b0;
                end
                if (wr_o) begin
                    chk_eq("wr_udre", 32'(udre_i), 32'(1));
                    chk_eq("one_outstanding", 32'(x_phase), 32'(0));
                    chk_eq("addr", 32'(addr_o), 32'(TX_ADDR));
                    e = m_lock ? m_owner : pick_first();
                    if (e < 0) begin
                        chk_eq("wr_unexpected", 32'(wr_o), 32'(0));
                    end else begin
                        b = q[e][0];
                        chk_eq("ready_who", 32'(req_ready), 32'(1) << e);
                        chk_eq("grant_who", 32'(grant_o), 32'(1) << e);
                        chk_eq("data", 32'(dout_o), 32'(b[7:0]));
                        m_cnt++;
                        m_pend = 1'b1;
                        if (b[8] || m_cnt >= BURST_MAX) begin
                            m_lock = 1'b0; m_cnt = 0; m_ptr = (e + 1) % NREQ;
                        end else begin
                            m_lock = 1'b1; m_owner = e;
                        end
                    end
                    x_phase = 1;
                    x_d1 = $urandom_range(0, 2);
                    x_d2 = (x_long || $urandom_range(0, 5) == 0) ? 20 : $urandom_range(1, 4);
                end
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
                if (x_phase == 1 && !x_stuck) begin
                    if (x_d1 == 0) x_phase = 2; else x_d1--;
                end else if (x_phase == 2) begin
                    if (x_d2 == 0) x_phase = 0; else x_d2--;
                end
            end
            udre_i = (x_phase != 2);
            txc_i  = txc_rand ? 1'($urandom_range(0, 1)) : txc_force;
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (q[i].size() > 0);
                req_data[8*i +: 8] = req_valid[i] ? q[i][0][7:0] : 8'h00;
                req_last[i] = req_valid[i] ? q[i][0][8] : 1'b0;
            end
        end
    end

    initial begin
        int  pulses;
        bit  seen;
        n_chk = 0; n_pass = 0;
        x_stuck = 0; x_long = 0; txc_rand = 0; txc_force = 0;
        x_d1 = 0; x_d2 = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_wr", 32'(wr_o), 32'(0));
        chk_eq("rst_addr", 32'(addr_o), 32'(0));
        chk_eq("rst_dout", 32'(dout_o), 32'(0));
        chk_eq("rst_ready", 32'(req_ready), 32'(0));
        chk_eq("rst_grant", 32'(grant_o), 32'(0));
        chk_eq("rst_busy", 32'(busy_o), 32'(0));
        chk_eq("rst_tcack", 32'(tcack_o), 32'(0));
        chk_eq("rst_err", 32'(err_o), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // req0 and req2 single bytes from pointer 0; pointer ends at 3.
        q[0].push_back({1'b1, 8'hA0});
        q[2].push_back({1'b1, 8'hB2});
        drain(300);

        // req1 three-byte burst while req3 waits.
        q[1].push_back({1'b0, 8'h11});
        q[1].push_back({1'b0, 8'h22});
        q[1].push_back({1'b1, 8'h33});
        q[3].push_back({1'b1, 8'h3C});
        drain(400);

        // Long unterminated run from req0 forces release at BURST_MAX.
        push_burst(0, 20, 1'b0);
        push_burst(1, 2, 1'b0);
        drain(2000);

        // Transmitter keeps the register full for 20 cycles, then TC ack.
        x_long = 1;
        q[1].push_back({1'b1, 8'h5A});
        drain(400);
        x_long = 0;
        chk_eq("pend_before_tc", 32'(m_pend), 32'(1));
        txc_force = 1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (tcack_o) pulses++;
        end
        chk_eq("tcack_count", 32'(pulses), 32'(1));
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (tcack_o) pulses++;
        end
        chk_eq("tcack_once", 32'(pulses), 32'(0));
        txc_force = 0;

        // Randomized rounds.
        txc_rand = 1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 3) != 0) push_burst(i, $urandom_range(1, 6), 1'b1);
            if ($urandom_range(0, 3) == 0) push_burst($urandom_range(0, NREQ - 1), 18, 1'b0);
            drain(3000);
        end
        txc_rand = 0;
        repeat (3) @(negedge clk);

        // Asynchronous reset while a write strobe is high.
        q[3].push_back({1'b1, 8'hD3});
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk); #1;
            if (wr_o) seen = 1'b1;
        end
        chk_eq("mid_wr_seen", 32'(seen), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_wr", 32'(wr_o), 32'(0));
        chk_eq("mid_rst_ready", 32'(req_ready), 32'(0));
        chk_eq("mid_rst_grant", 32'(grant_o), 32'(0));
        chk_eq("mid_rst_busy", 32'(busy_o), 32'(0));
        chk_eq("mid_rst_addr", 32'(addr_o), 32'(0));
        chk_eq("mid_rst_dout", 32'(dout_o), 32'(0));
        model_reset();
        q[0].push_back({1'b1, 8'hE0});
        @(negedge clk);
        rst_n = 1'b1;
        drain(300);
        chk_eq("err_default", 32'(err_o), 32'(0));

`ifdef UART_TX_ARB_TIMEOUT_EN
        x_stuck = 1;
        q[2].push_back({1'b1, 8'hF2});
        seen = 1'b0;
        for (int c = 0; c < 70000 && !seen; c++) begin
            @(posedge clk); #1;
            if (err_o) seen = 1'b1;
        end
        chk_eq("wdog_err", 32'(err_o), 32'(1));
        chk_eq("wdog_grant", 32'(grant_o), 32'(0));
        chk_eq("wdog_busy", 32'(busy_o), 32'(0));
        x_stuck = 0;
        x_phase = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the UART transmitter's data-register write port (din/addr/write, udren, txcn_flag, tcack) between NREQ byte-stream requesters.
- Uses round-robin arbitration with optional burst lock, so one requester's multi-byte frame goes out contiguously.
- Sits between on-chip clients and the transmitter's register interface. Runs on the same clock as the transmitter register side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TX_ADDR, 8'hC6, register address driven on addr_o during a data write.
- BURST_MAX, 16, maximum bytes a locked requester may send before forced release (1..255).

Ports:
- clk  in  1  block clock; same clock as the transmitter register side.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a byte available.
- req_data  in  8*NREQ  byte for requester i, in bits [8i+7:8i].
- req_last  in  NREQ  byte is the last of requester i's burst; ignored when not granted.
- req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
- udre_i  in  1  transmitter data-register-empty flag (udren).
- txc_i  in  1  transmitter transmit-complete flag (txcn_flag).
- wr_o  out  1  write strobe to transmitter.
- addr_o  out  8  register address.
- dout_o  out  8  write data.
- tcack_o  out  1  transmit-complete acknowledge pulse.
- grant_o  out  NREQ  one-hot current owner; all zero when none.
- busy_o  out  1  high in any state except IDLE.
- err_o  out  1  sticky timeout error; present only with the optional feature, else tied 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; wr_o=0; addr_o=0; dout_o=0; tcack_o=0; req_ready=0; grant_o=0; busy_o=0; err_o=0.
  - RR pointer=0; burst count=0; pending_tc=0.
- States: IDLE, GRANT, WRITE, WAIT_TAKE, WAIT_RDY.
- IDLE:
  - If any req_valid and udre_i=1 -> GRANT.
  - Winner = first valid index at or after the RR pointer, wrapping NREQ-1 -> 0.
  - grant_o is registered on entry to GRANT.
- GRANT: one cycle; latch req_data of the winner -> WRITE.
- WRITE: exactly one cycle.
  - wr_o=1, addr_o=TX_ADDR, dout_o=latched byte.
  - req_ready[winner]=1 in the same cycle.
  - Burst count +1; set pending_tc=1.
  - -> WAIT_TAKE.
  - Latency: IDLE with valid & udre_i -> wr_o high after exactly 2 clocks.
- WAIT_TAKE: wait for udre_i=0 (transmitter accepted the byte) -> WAIT_RDY. wr_o=0 and addr_o held.
- WAIT_RDY: wait for udre_i=1, then:
  - Lock continues (keep grant, -> GRANT) when: last accepted byte had req_last=0, winner req_valid=1, and burst count < BURST_MAX.
  - Otherwise release:
    - RR pointer = winner+1 (mod NREQ); burst count=0; grant_o=0.
    - -> IDLE, or directly -> GRANT with a fresh RR pick if any other valid.
  - Lock held but winner req_valid=0: stay in WAIT_RDY holding grant until it is valid again.
- Forced release at BURST_MAX: behaves as req_last=1 for pointer update. The requester's next byte competes in a fresh round.
- tcack_o:
  - One-cycle pulse when pending_tc=1, state=IDLE, udre_i=1 and txc_i=1; clears pending_tc.
  - Never asserted while a write is outstanding.
- Simultaneous events:
  - req_valid dropping during GRANT: byte already latched; the write still occurs and req_ready still pulses (requesters must hold valid until ready).
  - udre_i high in WAIT_TAKE is not treated as taken; only the falling edge counts.
- Only one write is outstanding at any time. wr_o is never asserted while udre_i=0.
- RR pointer width is clog2(NREQ). Burst count is 8 bits, saturating at BURST_MAX.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- When defined:
  - 16-bit watchdog counts cycles in WAIT_TAKE and WAIT_RDY, clearing on each state entry.
  - At 16'hFFFF: set sticky err_o, release grant, advance RR pointer, -> IDLE.
  - err_o clears only on reset.
- When undefined: no counter; the block waits indefinitely; err_o is constant 0.

Decomposition:
- Package uart_pkg holds:
  - state encoding typedef (IDLE..WAIT_RDY);
  - UDR_ADDR constant 8'hC6;
  - UART_TX_ARB_WDOG_MAX constant.
- One sub-module, rr_pick:
  - Combinational round-robin priority selector.
  - Inputs: valid vector, pointer. Outputs: one-hot grant, found flag.
  - Instantiated once.

Test Plan:
- Reset mid-WRITE (rst_n low while wr_o=1) -> all outputs 0 the same cycle, state IDLE, pointer 0.
- Req0 and req2 valid, udre_i=1, pointer 0 -> req0 written first (dout_o=req0 byte, addr_o=8'hC6), then req2; pointer=3 after.
- Req1 bursts 3 bytes 8'h11, 8'h22, 8'h33 (req_last on third) while req3 also valid -> three consecutive req1 writes, then req3.
- BURST_MAX=2, req0 sends 5 bytes, req_last never set, req1 valid -> order 0,0,1,0,0,1...
- udre_i held low 20 cycles after a write -> no further wr_o until udre_i rises; then tcack_o pulses once when txc_i=1 in IDLE.
- UART_TX_ARB_TIMEOUT_EN defined, udre_i stuck high after write -> err_o=1 after 65535 cycles in WAIT_TAKE, grant_o=0, busy_o=0.
